// File: rtl/fmul_issue.sv
// Issue/capture wrapper around an external combinational FP multiplier: holds
// operands for LATENCY cycles, captures the product and flags, and hands them off.
module fmul_issue #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_s,
  input  logic [31:0]      req_t,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      mul_s,
  output logic [31:0]      mul_t,
  input  logic [31:0]      mul_d,
  input  logic             mul_overflow,
  input  logic             mul_underflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_d,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic             busy,
  output logic [15:0]      done_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_mul_s;
  logic [31:0]      r_mul_t;
  logic [31:0]      r_rsp_d;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_ovf;
  logic             r_rsp_unf;
  logic [15:0]      r_done_count;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_req_ready;
  logic       w_accept;
  logic       w_capture;
  logic       w_rsp_hs;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_rsp_hs    = 1'b0;
    w_req_ready = ((r_state == IDLE) || ((r_state == DONE) && rsp_ready)) && !rst && !flush;
    w_accept    = req_valid && w_req_ready;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_rsp_hs = 1'b1;
          // A new accept in the handshake cycle issues back-to-back with no bubble.
          if (w_accept) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_INIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
      w_capture   = 1'b0;
      w_rsp_hs    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_mul_s      <= '0;
      r_mul_t      <= '0;
      r_rsp_d      <= '0;
      r_rsp_tag    <= '0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_unf    <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // The tag may be overwritten on accept: the old response is consumed that same edge.
      if (w_accept) begin
        r_mul_s   <= req_s;
        r_mul_t   <= req_t;
        r_rsp_tag <= req_tag;
      end
      if (w_capture) begin
        r_rsp_d   <= mul_d;
        r_rsp_ovf <= mul_overflow;
        r_rsp_unf <= mul_underflow;
      end
      if (w_rsp_hs) begin
        r_done_count <= r_done_count + 16'd1;
      end
    end
  end

  assign req_ready     = w_req_ready;
  assign mul_s         = r_mul_s;
  assign mul_t         = r_mul_t;
  assign rsp_valid     = (r_state == DONE);
  assign rsp_d         = r_rsp_d;
  assign rsp_tag       = r_rsp_tag;
  assign rsp_overflow  = r_rsp_ovf;
  assign rsp_underflow = r_rsp_unf;
  assign busy          = (r_state == WAIT) || (r_state == DONE);
  assign done_count    = r_done_count;

endmodule

// File: tb/tb_fmul_issue.sv
// Directed scoreboard bench for fmul_issue: a LATENCY=2 instance carries the main
// traffic, a LATENCY=3 instance sharing the inputs is used for the flush scenario.
module tb_fmul_issue;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, rsp_ready;
  logic [31:0] req_s, req_t;
  logic [5:0]  req_tag;

  logic        req_ready, rsp_valid, rsp_ovf, rsp_unf, busy;
  logic [31:0] mul_s, mul_t, mul_d, rsp_d;
  logic [5:0]  rsp_tag;
  logic [15:0] done_count;
  logic        mul_ovf, mul_unf;

  logic        req_ready_3, rsp_valid_3, rsp_ovf_3, rsp_unf_3, busy_3;
  logic [31:0] mul_s_3, mul_t_3, mul_d_3, rsp_d_3;
  logic [5:0]  rsp_tag_3;
  logic [15:0] done_count_3;
  logic        mul_ovf_3, mul_unf_3;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  tag;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Stand-in multiplier: a lookup of the exact products used below, returns {ovf, unf, d}.
  function automatic logic [33:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      {32'h4000_0000, 32'h4040_0000},
      {32'h4040_0000, 32'h4000_0000}: return {2'b00, 32'h40C0_0000};
      {32'h3FC0_0000, 32'h3FC0_0000}: return {2'b00, 32'h4010_0000};
      {32'h4000_0000, 32'h4000_0000}: return {2'b00, 32'h4080_0000};
      {32'h3F80_0000, 32'h3F80_0000}: return {2'b00, 32'h3F80_0000};
      {32'h7F00_0000, 32'h7F00_0000}: return {2'b10, 32'h7F80_0000};
      {32'h0080_0000, 32'h0080_0000}: return {2'b01, 32'h0000_0000};
      default:                        return {2'b00, a ^ b};
    endcase
  endfunction

  assign {mul_ovf, mul_unf, mul_d}       = fmul_model(mul_s, mul_t);
  assign {mul_ovf_3, mul_unf_3, mul_d_3} = fmul_model(mul_s_3, mul_t_3);

  fmul_issue #(.LATENCY(2), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_t(req_t), .req_tag(req_tag),
    .mul_s(mul_s), .mul_t(mul_t), .mul_d(mul_d),
    .mul_overflow(mul_ovf), .mul_underflow(mul_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d(rsp_d), .rsp_tag(rsp_tag),
    .rsp_overflow(rsp_ovf), .rsp_underflow(rsp_unf),
    .busy(busy), .done_count(done_count)
  );

  fmul_issue #(.LATENCY(3), .TAG_W(6)) dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready_3),
    .req_s(req_s), .req_t(req_t), .req_tag(req_tag),
    .mul_s(mul_s_3), .mul_t(mul_t_3), .mul_d(mul_d_3),
    .mul_overflow(mul_ovf_3), .mul_underflow(mul_unf_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
    .rsp_d(rsp_d_3), .rsp_tag(rsp_tag_3),
    .rsp_overflow(rsp_ovf_3), .rsp_underflow(rsp_unf_3),
    .busy(busy_3), .done_count(done_count_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Inputs are set just after a rising edge; the handshake is sampled at the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_d", rsp_d, e.d);
        check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        check("rsp_overflow", 32'(rsp_ovf), 32'(e.ovf));
        check("rsp_underflow", 32'(rsp_unf), 32'(e.unf));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int max_cycles);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drive_req(input logic [31:0] s, input logic [31:0] t, input logic [5:0] tag);
    req_valid = 1'b1;
    req_s     = s;
    req_t     = t;
    req_tag   = tag;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [5:0] tag, input logic ovf, input logic unf);
    exp_t e;
    e.d   = d;
    e.tag = tag;
    e.ovf = ovf;
    e.unf = unf;
    sb.push_back(e);
  endtask

  task automatic check_reset_state();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_d", rsp_d, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_flags", {30'd0, rsp_ovf, rsp_unf}, 32'd0);
    check("rst_mul_s", mul_s, 32'd0);
    check("rst_mul_t", mul_t, 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] held_d;
    logic [5:0]  held_tag;

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_s = '0; req_t = '0; req_tag = '0;
    @(posedge clk); #1;
    tick();
    check_reset_state();
    check("ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Single operation: 2.0 * 3.0, latency 2.
    rsp_ready = 1'b1;
    drive_req(32'h4000_0000, 32'h4040_0000, 6'd5);
    check("acc1_ready", 32'(req_ready), 32'd1);
    push_exp(32'h40C0_0000, 6'd5, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    check("acc1_busy", 32'(busy), 32'd1);
    check("acc1_mul_s", mul_s, 32'h4000_0000);
    check("acc1_mul_t", mul_t, 32'h4040_0000);
    check("lat_e0_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("lat_e1_valid", 32'(rsp_valid), 32'd0);
    check("lat_e1_mul_s", mul_s, 32'h4000_0000);
    tick();
    check("lat_e2_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("op1_done_count", 32'(done_count), 32'd1);
    check("op1_idle", 32'(busy), 32'd0);

    // Back-to-back: second accept coincides with first response handshake.
    drive_req(32'h3FC0_0000, 32'h3FC0_0000, 6'd1);
    push_exp(32'h4010_0000, 6'd1, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("b2b_first_valid", 32'(rsp_valid), 32'd1);
    drive_req(32'h4000_0000, 32'h4000_0000, 6'd2);
    check("b2b_ready_in_hs", 32'(req_ready), 32'd1);
    push_exp(32'h4080_0000, 6'd2, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_mul_s", mul_s, 32'h4000_0000);
    check("b2b_done_count1", 32'(done_count), 32'd2);
    tick();
    tick();
    check("b2b_second_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("b2b_done_count2", 32'(done_count), 32'd3);

    // Overflow passthrough.
    drive_req(32'h7F00_0000, 32'h7F00_0000, 6'd7);
    push_exp(32'h7F80_0000, 6'd7, 1'b1, 1'b0);
    tick();
    req_valid = 1'b0;
    wait_rsp(8);
    tick();
    check("ovf_done_count", 32'(done_count), 32'd4);

    // Back-pressure with a pending request held on the input.
    rsp_ready = 1'b0;
    drive_req(32'h4040_0000, 32'h4000_0000, 6'd9);
    push_exp(32'h40C0_0000, 6'd9, 1'b0, 1'b0);
    tick();
    drive_req(32'h3F80_0000, 32'h3F80_0000, 6'd10);
    wait_rsp(8);
    held_d   = rsp_d;
    held_tag = rsp_tag;
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_d", rsp_d, 32'h40C0_0000);
      check("bp_tag_stable", 32'(rsp_tag), 32'(held_tag));
      check("bp_d_stable", rsp_d, held_d);
      check("bp_mul_s", mul_s, 32'h4040_0000);
      tick();
    end
    check("bp_done_count_hold", 32'(done_count), 32'd4);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    push_exp(32'h3F80_0000, 6'd10, 1'b0, 1'b0);
    tick();
    req_valid = 1'b0;
    check("bp_one_hs", 32'(done_count), 32'd5);
    check("bp_next_op_busy", 32'(busy), 32'd1);
    wait_rsp(8);
    tick();
    check("bp_done_count_end", 32'(done_count), 32'd6);

    // Flush one cycle after accept; both instances start from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_req(32'h4000_0000, 32'h4040_0000, 6'd3);
    #1;
    check("fl_ready", 32'(req_ready), 32'd1);
    check("fl_ready_3", 32'(req_ready_3), 32'd1);
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_ready_during", 32'(req_ready), 32'd0);
    check("fl_ready_during_3", 32'(req_ready_3), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_ready_after", 32'(req_ready), 32'd1);
    check("fl_ready_after_3", 32'(req_ready_3), 32'd1);
    check("fl_busy_3", 32'(busy_3), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("fl_no_valid", 32'(rsp_valid), 32'd0);
      check("fl_no_valid_3", 32'(rsp_valid_3), 32'd0);
      check("fl_done_count_3", 32'(done_count_3), 32'd0);
      tick();
    end
    check("fl_done_count", 32'(done_count), 32'd0);

    // Reset while holding a result in DONE discards it.
    rsp_ready = 1'b0;
    drive_req(32'h0080_0000, 32'h0080_0000, 6'd11);
    tick();
    req_valid = 1'b0;
    wait_rsp(8);
    check("done_unf", 32'(rsp_unf), 32'd1);
    check("done_tag", 32'(rsp_tag), 32'd11);
    rst = 1'b1;
    tick();
    check_reset_state();
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("post_rst_no_valid", 32'(rsp_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fmul_issue.md
FMUL_ISSUE -- requirements
Module: fmul_issue

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning the number of cycles operands are held stable on mul_s/mul_t before the result is sampled; legal range 1..15.
REQ-002 SHALL have parameter TAG_W, default 6, meaning the width of the destination tag carried alongside each operation.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  synchronous cancel of any in-flight or unconsumed operation.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block accepts request this cycle.
REQ-009 req_s, req_t  input  32  IEEE-754 single operands.
REQ-010 req_tag  input  TAG_W  destination tag.
REQ-011 mul_s, mul_t  output  32  registered operands driven to the combinational multiplier.
REQ-012 mul_d  input  32  multiplier product.
REQ-013 mul_overflow, mul_underflow  input  1  multiplier exception flags.
REQ-014 rsp_valid  output  1  result present.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_d  output  32  captured product.
REQ-017 rsp_tag  output  TAG_W  tag of the captured operation.
REQ-018 rsp_overflow, rsp_underflow  output  1  captured flags.
REQ-019 busy  output  1  high in WAIT or DONE.
REQ-020 done_count  output  16  count of completed response handshakes; wraps from 0xFFFF to 0.

Function
REQ-021 SHALL implement the states IDLE, WAIT and DONE, with a 4-bit down-counter cnt.
REQ-022 Accept is req_valid && req_ready; req_ready SHALL equal (IDLE || (DONE && rsp_ready)) && !rst && !flush.
REQ-023 On accept, the block SHALL register req_s/req_t into mul_s/mul_t, register req_tag, load cnt=LATENCY-1 and enter WAIT.
REQ-024 In WAIT with cnt!=0, cnt SHALL decrement and mul_s/mul_t SHALL remain unchanged.
REQ-025 In WAIT with cnt==0, the block SHALL capture mul_d and the flags into rsp_d/rsp_overflow/rsp_underflow and enter DONE.
REQ-026 Latency: for an accept at edge E0, the capture SHALL occur at edge E_LATENCY and rsp_valid SHALL be high from E_LATENCY onward.
REQ-027 rsp_valid SHALL be high exactly in DONE.
REQ-028 rsp_d/rsp_tag/flags SHALL be held stable while rsp_valid && !rsp_ready, for any number of cycles.
REQ-029 On DONE && rsp_ready, done_count SHALL increment; next state SHALL be WAIT if an accept occurs in the same cycle (back-to-back, no bubble), else IDLE.
REQ-030 req_valid SHALL be ignored in WAIT and in DONE without rsp_ready; the block SHALL NOT drop or overwrite any operation.
REQ-031 flush SHALL force IDLE, rsp_valid=0 and cnt=0 on the next edge, and SHALL NOT increment done_count; flush SHALL override a simultaneous accept or response handshake.
REQ-032 mul_s/mul_t SHALL retain their last value in IDLE and DONE.
REQ-033 Exception semantics (NaN, inf, denormal) SHALL be passed through from the multiplier unmodified; this block SHALL perform no arithmetic.

Reset
REQ-034 rst SHALL have priority over flush and all handshakes.
REQ-035 After reset: state=IDLE, cnt=0, rsp_valid=0, rsp_d=0, rsp_tag=0, rsp_overflow=0, rsp_underflow=0, mul_s=0, mul_t=0, done_count=0, busy=0.
REQ-036 Asserting rst mid-WAIT or mid-DONE SHALL discard the operation with no response produced.

Verification
REQ-037 LATENCY=2, req 0x40000000*0x40400000, tag 5, rsp_ready=1 -> rsp_valid high exactly 2 cycles after accept, rsp_d=0x40C00000, rsp_tag=5, flags 0, done_count=1.
REQ-038 Back-to-back requests 0x3FC00000*0x3FC00000 then 0x40000000*0x40000000 with rsp_ready=1 -> results 0x40100000 then 0x40800000, second accepted in the same cycle as the first response handshake.
REQ-039 Request 0x7F000000*0x7F000000 -> rsp_d=0x7F800000, rsp_overflow=1.
REQ-040 rsp_ready=0 for 5 cycles after rsp_valid while req_valid stays high -> req_ready=0, outputs stable, and exactly one handshake once rsp_ready=1.
REQ-041 flush one cycle after accept (LATENCY=3) -> no rsp_valid, done_count unchanged, req_ready=1 on the next cycle.
REQ-042 rst asserted in DONE -> all outputs return to the REQ-035 values on the next edge.
